// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operation handshake and data bundle for serial_subtractor.
//               master drives the request (start, x, y, bin) and observes the
//               status/result; slave is the subtractor side.
//   start  request a new operation
//   x, y   minuend / subtrahend (WIDTH bits)
//   bin    borrow in
//   busy   operation in progress
//   done   one-cycle pulse, result valid
//   d      difference (WIDTH bits)
//   b      borrow out
//   zero   difference is zero
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b;
  logic             zero;

  modport master (
    output start, x, y, bin,
    input  busy, done, d, b, zero
  );

  modport slave (
    input  start, x, y, bin,
    output busy, done, d, b, zero
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor, d = x - y - bin (mod 2^WIDTH)
//               computed STEP bits per clock, LSB first, through a registered
//               borrow. One operation takes WIDTH/STEP RUN cycles followed by
//               a single DONE cycle.
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   bus    serial_subtractor_if.slave: start/x/y/bin in,
//          busy/done/d/b/zero out (all outputs registered or state decodes)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  serial_subtractor_if.slave   bus
);

  localparam int C_N  = WIDTH / STEP;
  localparam int C_CW = $clog2(C_N + 1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);
  localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_b;
  logic             r_zero;
  logic [C_CW-1:0]  r_cnt;

  logic [STEP:0]    w_diff;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;

  // One slice of the borrow chain: STEP+1 bit result, MSB is the borrow out.
  assign w_diff = {1'b0, r_xs[STEP-1:0]} - {1'b0, r_ys[STEP-1:0]}
                - {{STEP{1'b0}}, r_br};

  // New slice enters at the top; after N steps the first slice sits at bit 0.
  assign w_acc_next = (r_acc >> STEP)
                    | (WIDTH'(w_diff[STEP-1:0]) << (WIDTH - STEP));

  assign w_last   = (r_cnt == C_LAST);
  assign w_accept = bus.start && ((r_state == C_IDLE) || (r_state == C_DONE));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE:  w_state_next = bus.start ? C_RUN : C_IDLE;
      C_RUN:   w_state_next = w_last ? C_DONE : C_RUN;
      C_DONE:  w_state_next = bus.start ? C_RUN : C_IDLE;
      default: w_state_next = C_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      C_RUN:   w_busy = 1'b1;
      C_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath: operand shifters, borrow, partial difference and result regs.
  // Result registers are written only on the final RUN edge so they hold
  // the previous answer through IDLE and the next RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xs   <= '0;
      r_ys   <= '0;
      r_acc  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_b    <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_xs  <= bus.x;
      r_ys  <= bus.y;
      r_br  <= bus.bin;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == C_RUN) begin
      r_xs  <= r_xs >> STEP;
      r_ys  <= r_ys >> STEP;
      r_acc <= w_acc_next;
      r_br  <= w_diff[STEP];
      r_cnt <= r_cnt + C_ONE;
      if (w_last) begin
        r_d    <= w_acc_next;
        r_b    <= w_diff[STEP];
        r_zero <= (w_acc_next == '0);
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.d    = r_d;
  assign bus.b    = r_b;
  assign bus.zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Instantiates an
//               8-bit/1-bit-per-step and a 16-bit/4-bits-per-step instance
//               and checks results, handshake timing, result holding,
//               back-to-back operation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] d;
    logic        b;
    logic        z;
  } vec_t;

  logic clk;
  logic reset;
  bit   sel;          // 0: 8-bit instance, 1: 16-bit instance
  int   n_chk;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(8))  if8  ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  serial_subtractor #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  wire        w_busy = sel ? if16.busy : if8.busy;
  wire        w_done = sel ? if16.done : if8.done;
  wire [15:0] w_d    = sel ? if16.d    : {8'h00, if8.d};
  wire        w_b    = sel ? if16.b    : if8.b;
  wire        w_zero = sel ? if16.zero : if8.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic bin, input logic st);
    if (sel) begin
      if16.x = x; if16.y = y; if16.bin = bin; if16.start = st;
    end else begin
      if8.x = x[7:0]; if8.y = y[7:0]; if8.bin = bin; if8.start = st;
    end
  endtask

  task automatic set_start(input logic st);
    if (sel) if16.start = st;
    else     if8.start  = st;
  endtask

  // Samples #1 after each edge until done; counts edges and busy samples.
  task automatic wait_done(output int edges, inout int busy_cnt);
    bit overlap;
    overlap = 0;
    edges   = 0;
    while (!w_done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (w_busy) busy_cnt++;
      if (w_busy && w_done) overlap = 1;
    end
    chk("busy_done_overlap", {31'd0, overlap}, 32'd0);
    chk("done_seen", {31'd0, w_done}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic ez, input string nm);
    int n, edges, busy_cnt;
    n = sel ? 4 : 8;
    @(negedge clk);
    drive(x, y, bin, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    chk({nm, "_busy_after_accept"}, {31'd0, w_busy}, 32'd1);
    busy_cnt = 1;
    wait_done(edges, busy_cnt);
    chk({nm, "_latency"}, edges, n);
    chk({nm, "_busy_cycles"}, busy_cnt, n);
    chk({nm, "_d"}, {16'd0, w_d}, {16'd0, ed});
    chk({nm, "_b"}, {31'd0, w_b}, {31'd0, eb});
    chk({nm, "_zero"}, {31'd0, w_zero}, {31'd0, ez});
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, {31'd0, w_done}, 32'd0);
  endtask

  initial begin
    vec_t v8[9];
    int edges, bc;
    bit seen;
    logic [15:0] rx, ry;
    logic        rb;
    logic [16:0] full;

    v8[0] = '{16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0};
    v8[1] = '{16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0};
    v8[2] = '{16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0};
    v8[3] = '{16'hAA, 16'hAA, 1'b0, 16'h00, 1'b0, 1'b1};
    v8[4] = '{16'h10, 16'h01, 1'b0, 16'h0F, 1'b0, 1'b0};
    v8[5] = '{16'hFF, 16'h00, 1'b1, 16'hFE, 1'b0, 1'b0};
    v8[6] = '{16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 1'b0};
    v8[7] = '{16'h80, 16'h7F, 1'b1, 16'h00, 1'b0, 1'b1};
    v8[8] = '{16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, 1'b0};

    n_chk  = 0;
    n_fail = 0;
    sel    = 0;
    reset  = 1'b1;
    if8.start = 1'b0;  if8.x = '0;  if8.y = '0;  if8.bin = 1'b0;
    if16.start = 1'b0; if16.x = '0; if16.y = '0; if16.bin = 1'b0;

    // Reset state of both instances
    #12;
    chk("rst8_busy", {31'd0, if8.busy}, 32'd0);
    chk("rst8_done", {31'd0, if8.done}, 32'd0);
    chk("rst8_d",    {24'd0, if8.d}, 32'd0);
    chk("rst8_b",    {31'd0, if8.b}, 32'd0);
    chk("rst8_zero", {31'd0, if8.zero}, 32'd0);
    chk("rst16_busy", {31'd0, if16.busy}, 32'd0);
    chk("rst16_d",    {16'd0, if16.d}, 32'd0);
    chk("rst16_zero", {31'd0, if16.zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven 8-bit vectors
    for (int i = 0; i < 9; i++) begin
      run_op(v8[i].x, v8[i].y, v8[i].bin, v8[i].d, v8[i].b, v8[i].z, $sformatf("v8_%0d", i));
    end

    // Result holds through the next RUN; mid-RUN start and input changes ignored
    run_op(16'hAA, 16'hAA, 1'b0, 16'h00, 1'b0, 1'b1, "aa");
    @(negedge clk);
    drive(16'h10, 16'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_d",    {16'd0, w_d}, 32'd0);
      chk("hold_zero", {31'd0, w_zero}, 32'd1);
    end
    @(negedge clk);
    drive(16'hFF, 16'h00, 1'b1, 1'b1);
    @(negedge clk);
    set_start(1'b0);
    bc = 0;
    wait_done(edges, bc);
    chk("midrun_d",    {16'd0, w_d}, 32'h0F);
    chk("midrun_b",    {31'd0, w_b}, 32'd0);
    chk("midrun_zero", {31'd0, w_zero}, 32'd0);
    @(posedge clk); #1;
    chk("midrun_idle_busy", {31'd0, w_busy}, 32'd0);
    chk("midrun_idle_done", {31'd0, w_done}, 32'd0);

    // Back-to-back: start held high, second operation accepted from DONE
    @(negedge clk);
    drive(16'h05, 16'h03, 1'b0, 1'b1);
    @(posedge clk); #1;
    bc = 1;
    wait_done(edges, bc);
    chk("b2b_first_latency", edges, 8);
    chk("b2b_first_d", {16'd0, w_d}, 32'h02);
    drive(16'h20, 16'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("b2b_busy_from_done", {31'd0, w_busy}, 32'd1);
    chk("b2b_done_low", {31'd0, w_done}, 32'd0);
    set_start(1'b0);
    bc = 1;
    wait_done(edges, bc);
    chk("b2b_period", edges + 1, 9);
    chk("b2b_second_d", {16'd0, w_d}, 32'h1F);
    chk("b2b_second_b", {31'd0, w_b}, 32'd0);

    // Asynchronous reset in the 4th RUN cycle
    @(posedge clk); #1;
    @(negedge clk);
    drive(16'h33, 16'h11, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, w_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, w_busy}, 32'd0);
    chk("arst_done", {31'd0, w_done}, 32'd0);
    chk("arst_d",    {16'd0, w_d}, 32'd0);
    chk("arst_b",    {31'd0, w_b}, 32'd0);
    chk("arst_zero", {31'd0, w_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (w_done || w_busy) seen = 1;
    end
    chk("arst_no_done", {31'd0, seen}, 32'd0);
    run_op(16'h33, 16'h11, 1'b0, 16'h22, 1'b0, 1'b0, "post_rst");

    // 16-bit, 4 bits per step
    sel = 1;
    run_op(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, "w16_a");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "w16_b");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "w16_c");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b0, "w16_d");
    run_op(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, "w16_e");
    for (int i = 0; i < 16; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rb = 1'($urandom);
      full = {1'b0, rx} - {1'b0, ry} - {16'd0, rb};
      run_op(rx, ry, rb, full[15:0], full[16], (full[15:0] == 16'd0),
             $sformatf("rnd_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised N-bit subtractor built around a registered borrow chain. It computes `x - y - bin` over WIDTH/STEP clock cycles, STEP bits per cycle, LSB first. A start/busy/done handshake frames each operation. It replaces single-bit combinational half/full subtractor cells wherever wide operands must be subtracted with a small datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- STEP, 1, bits processed per cycle; must divide WIDTH (1 ≤ STEP ≤ WIDTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- x  input  WIDTH  minuend; sampled on the accepting edge only.
- y  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- d  output  WIDTH  difference, registered.
- b  output  1  borrow out (1 when x < y + bin, unsigned).
- zero  output  1  high when d == 0.

## Operation
- Let N = WIDTH/STEP. There are three states: IDLE, RUN, DONE.
- Internal registers:
  - xs and ys: operand shift registers.
  - br: borrow.
  - acc: partial difference.
  - cnt: step counter, width clog2(N+1).
- Accept: an edge with start=1 in IDLE or DONE does the following.
  - Loads xs=x, ys=y, br=bin, cnt=0, acc=0.
  - Moves the state to RUN.
- RUN, each edge:
  - Takes the low STEP bits of xs and ys: {bo, s} = xs[STEP-1:0] - ys[STEP-1:0] - br, computed at STEP+1 bits.
  - bo is the MSB of that result.
  - Shifts xs and ys right by STEP.
  - Shifts s into acc from the MSB side, so acc shifts right by STEP.
  - Sets br=bo and increments cnt.
- When cnt reaches N-1 on a RUN edge, that edge also does the following.
  - Writes d = final acc, b = final bo, zero = (final acc == 0).
  - Moves the state to DONE.
- DONE lasts one cycle.
  - With start=1, it accepts a new operation (back-to-back) and goes to RUN.
  - Otherwise it goes to IDLE.
- Outputs d, b and zero change only on the edge entering DONE. They hold through IDLE and any following RUN until the next DONE.
- start is ignored in RUN. x, y and bin may change freely during RUN without affecting the result.
- Arithmetic is unsigned modulo 2^WIDTH: d = (x - y - bin) mod 2^WIDTH.
- Reset (asynchronous, any time, including mid-RUN) clears the following immediately.
  - State goes to IDLE.
  - busy=0, done=0, d=0, b=0, zero=0.
  - xs, ys, acc, br and cnt are cleared.
  - The in-flight operation is discarded; no done pulse follows.
- After reset deasserts, the first rising edge may accept a start.

## Timing
- Reset values: busy=0, done=0, d=0, b=0, zero=0. zero reads 0 after reset even though d=0; it is a result flag, not a live compare.
- Accept edge E0: busy rises after E0.
- RUN occupies edges E1..EN. The edge EN writes the outputs.
- busy is high for N cycles, then done is high for exactly the cycle after EN.
- Latency: start accepted at E0 → done high and d valid in the cycle following edge EN. That is N+1 edges after E0 (9 for WIDTH=8, STEP=1; 3 for STEP=4).
- Throughput with start held high: one result every N+1 cycles. done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, STEP=1; x=0x05, y=0x03, bin=0, one-cycle start → busy high 8 cycles, then done pulse for 1 cycle; d=0x02, b=0, zero=0.
- x=0x03, y=0x05, bin=0 → d=0xFE, b=1, zero=0. Also x=0x00, y=0x00, bin=1 → d=0xFF, b=1.
- x=y=0xAA, bin=0 → d=0x00, zero=1, b=0. Then start a second operation with x=0x10, y=0x01 → d, b and zero hold the old values during RUN and update to 0x0F/0/0 only at done.
- Pulse start again mid-RUN and change x/y/bin mid-RUN → pulse ignored, result unchanged. Hold start high across DONE → the next operation starts from DONE with no IDLE cycle.
- Assert reset at cycle 4 of RUN → all outputs go to 0 asynchronously, with no done pulse. A new start after release gives a correct result.
- WIDTH=16, STEP=4 instance: x=0x1234, y=0x0235, bin=0 → d=0x0FFF, b=0; done 5 edges after accept. Also run a random sweep against (x - y - bin) mod 2^16 and the borrow flag.
